// File: rtl/pci_cfg_target_if.sv
// PCI target-side bus plus config-space request/response signals.
interface pci_cfg_target_if;
    localparam int unsigned AD_W  = 32;
    localparam int unsigned CBE_W = 4;
    localparam int unsigned OFF_W = 6;

    // PCI pad side
    logic              pci_frame_n;
    logic              pci_irdy_n;
    logic              pci_idsel;
    logic [AD_W-1:0]   pci_ad_in;
    logic [CBE_W-1:0]  pci_cbe_n;
    logic [AD_W-1:0]   pci_ad_out;
    logic              pci_ad_oe;
    logic              pci_trdy_n;
    logic              pci_devsel_n;
    logic              pci_stop_n;
    logic              pci_ctl_oe;

    // Config-space block side
    logic              cfg_enable;
    logic              cfg_iswrite;
    logic [OFF_W-1:0]  cfg_offset;
    logic [AD_W-1:0]   cfg_write_val;
    logic [AD_W-1:0]   cfg_read_val;

    // Target view: the pci_cfg_target block
    modport slave (
        input  pci_frame_n, pci_irdy_n, pci_idsel, pci_ad_in, pci_cbe_n,
        input  cfg_read_val,
        output pci_ad_out, pci_ad_oe, pci_trdy_n, pci_devsel_n, pci_stop_n,
        output pci_ctl_oe,
        output cfg_enable, cfg_iswrite, cfg_offset, cfg_write_val
    );

    // Environment view: PCI initiator plus config-space block
    modport master (
        output pci_frame_n, pci_irdy_n, pci_idsel, pci_ad_in, pci_cbe_n,
        output cfg_read_val,
        input  pci_ad_out, pci_ad_oe, pci_trdy_n, pci_devsel_n, pci_stop_n,
        input  pci_ctl_oe,
        input  cfg_enable, cfg_iswrite, cfg_offset, cfg_write_val
    );
endinterface

// File: rtl/pci_cfg_target.sv
// PCI Type 0 configuration target: claims config reads/writes selected by
// IDSEL, runs a single-data-phase DEVSEL#/TRDY#/STOP# handshake and turns
// each claimed transaction into one cfg_enable pulse.
module pci_cfg_target #(
    parameter logic [3:0] CMD_CFG_RD = 4'hA,
    parameter logic [3:0] CMD_CFG_WR = 4'hB
) (
    input  logic                 clk,
    input  logic                 rst,
    pci_cfg_target_if.slave      bus
);
    localparam int unsigned AD_W  = 32;
    localparam int unsigned OFF_W = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLAIM    = 3'd1,
        RD_FETCH = 3'd2,
        DATA     = 3'd3,
        TURN     = 3'd4,
        BUSY     = 3'd5
    } state_e;

    state_e              state_q,       state_d;
    logic [AD_W-1:0]     ad_out_q,      ad_out_d;
    logic                ad_oe_q,       ad_oe_d;
    logic                trdy_n_q,      trdy_n_d;
    logic                devsel_n_q,    devsel_n_d;
    logic                stop_n_q,      stop_n_d;
    logic                ctl_oe_q,      ctl_oe_d;
    logic                cfg_en_q,      cfg_en_d;
    logic                iswrite_q,     iswrite_d;
    logic [OFF_W-1:0]    offset_q,      offset_d;
    logic [AD_W-1:0]     write_val_q,   write_val_d;

    logic                is_rd_c;
    logic                is_wr_c;
    logic                addr_match_c;

    // Address-phase decode: Type 0 config cycle aimed at this device
    assign is_rd_c      = (bus.pci_cbe_n == CMD_CFG_RD);
    assign is_wr_c      = (bus.pci_cbe_n == CMD_CFG_WR);
    assign addr_match_c = bus.pci_idsel && (bus.pci_ad_in[1:0] == 2'b00)
                          && (is_rd_c || is_wr_c);

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ad_out_q    <= '0;
            ad_oe_q     <= 1'b0;
            trdy_n_q    <= 1'b1;
            devsel_n_q  <= 1'b1;
            stop_n_q    <= 1'b1;
            ctl_oe_q    <= 1'b0;
            cfg_en_q    <= 1'b0;
            iswrite_q   <= 1'b0;
            offset_q    <= '0;
            write_val_q <= '0;
        end else begin
            state_q     <= state_d;
            ad_out_q    <= ad_out_d;
            ad_oe_q     <= ad_oe_d;
            trdy_n_q    <= trdy_n_d;
            devsel_n_q  <= devsel_n_d;
            stop_n_q    <= stop_n_d;
            ctl_oe_q    <= ctl_oe_d;
            cfg_en_q    <= cfg_en_d;
            iswrite_q   <= iswrite_d;
            offset_q    <= offset_d;
            write_val_q <= write_val_d;
        end
    end

    // Next-state and next-output logic; every register holds unless changed
    always_comb begin
        state_d     = state_q;
        ad_out_d    = ad_out_q;
        ad_oe_d     = ad_oe_q;
        trdy_n_d    = trdy_n_q;
        devsel_n_d  = devsel_n_q;
        stop_n_d    = stop_n_q;
        ctl_oe_d    = ctl_oe_q;
        cfg_en_d    = cfg_en_q;
        iswrite_d   = iswrite_q;
        offset_d    = offset_q;
        write_val_d = write_val_q;

        unique case (state_q)
            IDLE: begin
                if (!bus.pci_frame_n) begin
                    if (addr_match_c) begin
                        offset_d   = bus.pci_ad_in[7:2];
                        iswrite_d  = is_wr_c;
                        devsel_n_d = 1'b0;
                        ctl_oe_d   = 1'b1;
                        // Reads fetch early so data is ready for TRDY#
                        cfg_en_d   = is_rd_c;
                        state_d    = CLAIM;
                    end else begin
                        state_d    = BUSY;
                    end
                end
            end
            CLAIM: begin
                cfg_en_d = 1'b0;
                if (iswrite_q) begin
                    trdy_n_d = 1'b0;
                    stop_n_d = bus.pci_frame_n;
                    state_d  = DATA;
                end else begin
                    state_d  = RD_FETCH;
                end
            end
            RD_FETCH: begin
                ad_out_d = bus.cfg_read_val;
                ad_oe_d  = 1'b1;
                trdy_n_d = 1'b0;
                stop_n_d = bus.pci_frame_n;
                state_d  = DATA;
            end
            DATA: begin
                // Disconnect-with-data whenever the initiator wants more phases
                stop_n_d = bus.pci_frame_n;
                if (!bus.pci_irdy_n) begin
                    if (iswrite_q) begin
                        write_val_d = bus.pci_ad_in;
                        cfg_en_d    = 1'b1;
                    end
                    trdy_n_d   = 1'b1;
                    devsel_n_d = 1'b1;
                    stop_n_d   = 1'b1;
                    ad_oe_d    = 1'b0;
                    state_d    = TURN;
                end
            end
            TURN: begin
                // Control lines were driven high last cycle; now release them
                cfg_en_d = 1'b0;
                ctl_oe_d = 1'b0;
                state_d  = BUSY;
            end
            BUSY: begin
                if (bus.pci_frame_n && bus.pci_irdy_n) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.pci_ad_out    = ad_out_q;
    assign bus.pci_ad_oe     = ad_oe_q;
    assign bus.pci_trdy_n    = trdy_n_q;
    assign bus.pci_devsel_n  = devsel_n_q;
    assign bus.pci_stop_n    = stop_n_q;
    assign bus.pci_ctl_oe    = ctl_oe_q;
    assign bus.cfg_enable    = cfg_en_q;
    assign bus.cfg_iswrite   = iswrite_q;
    assign bus.cfg_offset    = offset_q;
    assign bus.cfg_write_val = write_val_q;
endmodule

// File: tb/tb_pci_cfg_target.sv
// Directed bench for pci_cfg_target: PCI initiator stimulus, a small
// config-space model, and a scoreboard of expected cfg_enable requests.
module tb_pci_cfg_target;
    typedef struct packed {
        logic        iswrite;
        logic [5:0]  offset;
        logic [31:0] wval;
    } cfg_req_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    cfg_req_t sb_q[$];

    pci_cfg_target_if bus ();

    pci_cfg_target #(.CMD_CFG_RD(4'hA), .CMD_CFG_WR(4'hB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Config-space ROM: read data valid the cycle after cfg_enable
    function automatic logic [31:0] rom(input logic [5:0] off);
        case (off)
            6'd0:    return 32'h1234_5678;
            6'd1:    return 32'hAABB_CCDD;
            default: return {26'h0, off};
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.cfg_enable && !bus.cfg_iswrite)
            bus.cfg_read_val <= rom(bus.cfg_offset);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every cfg_enable pulse must match the oldest expected request
    always @(negedge clk) begin
        if (rst && bus.cfg_enable) begin
            chk("sb_expected_req", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                cfg_req_t e;
                e = sb_q.pop_front();
                chk("sb_iswrite", 32'(bus.cfg_iswrite), 32'(e.iswrite));
                chk("sb_offset",  32'(bus.cfg_offset),  32'(e.offset));
                if (e.iswrite)
                    chk("sb_write_val", bus.cfg_write_val, e.wval);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.pci_frame_n = 1'b1;
        bus.pci_irdy_n  = 1'b1;
        bus.pci_idsel   = 1'b0;
        bus.pci_ad_in   = 32'h0;
        bus.pci_cbe_n   = 4'hF;
    endtask

    task automatic addr_phase(input logic [31:0] ad, input logic [3:0] cmd, input logic idsel);
        bus.pci_frame_n = 1'b0;
        bus.pci_irdy_n  = 1'b1;
        bus.pci_idsel   = idsel;
        bus.pci_ad_in   = ad;
        bus.pci_cbe_n   = cmd;
    endtask

    task automatic data_phase(input logic frame_n, input logic irdy_n, input logic [31:0] ad);
        bus.pci_frame_n = frame_n;
        bus.pci_irdy_n  = irdy_n;
        bus.pci_idsel   = 1'b0;
        bus.pci_ad_in   = ad;
        bus.pci_cbe_n   = 4'h0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_trdy_n"},   32'(bus.pci_trdy_n),   32'd1);
        chk({tag, "_devsel_n"}, 32'(bus.pci_devsel_n), 32'd1);
        chk({tag, "_stop_n"},   32'(bus.pci_stop_n),   32'd1);
        chk({tag, "_ad_oe"},    32'(bus.pci_ad_oe),    32'd0);
        chk({tag, "_ctl_oe"},   32'(bus.pci_ctl_oe),   32'd0);
        chk({tag, "_cfg_en"},   32'(bus.cfg_enable),   32'd0);
        chk({tag, "_iswrite"},  32'(bus.cfg_iswrite),  32'd0);
        chk({tag, "_ad_out"},   bus.pci_ad_out,        32'd0);
        chk({tag, "_offset"},   32'(bus.cfg_offset),   32'd0);
        chk({tag, "_wval"},     bus.cfg_write_val,     32'd0);
    endtask

    initial begin
        logic [31:0] bad_ad  [3];
        logic [3:0]  bad_cmd [3];
        logic        bad_sel [3];
        bad_ad  = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0000};
        bad_cmd = '{4'hA,          4'hA,          4'h6};
        bad_sel = '{1'b0,          1'b1,          1'b1};

        bus_idle();
        bus.cfg_read_val = 32'h0;
        rst = 1'b0;
        tick(); tick();
        chk_reset("reset");
        rst = 1'b1;
        tick();

        // Config read of offset 0, IRDY# ready immediately
        addr_phase(32'h0000_0000, 4'hA, 1'b1);
        sb_q.push_back('{iswrite: 1'b0, offset: 6'd0, wval: 32'h0});
        tick();
        chk("rd0_devsel_claim", 32'(bus.pci_devsel_n), 32'd0);
        chk("rd0_ctl_oe_claim", 32'(bus.pci_ctl_oe),   32'd1);
        chk("rd0_trdy_claim",   32'(bus.pci_trdy_n),   32'd1);
        data_phase(1'b1, 1'b0, 32'h0);
        tick();
        chk("rd0_trdy_fetch",   32'(bus.pci_trdy_n),   32'd1);
        tick();
        chk("rd0_trdy_data",    32'(bus.pci_trdy_n),   32'd0);
        chk("rd0_ad_out",       bus.pci_ad_out,        32'h1234_5678);
        chk("rd0_ad_oe",        32'(bus.pci_ad_oe),    32'd1);
        chk("rd0_stop_data",    32'(bus.pci_stop_n),   32'd1);
        tick();
        chk("rd0_trdy_turn",    32'(bus.pci_trdy_n),   32'd1);
        chk("rd0_devsel_turn",  32'(bus.pci_devsel_n), 32'd1);
        chk("rd0_ad_oe_turn",   32'(bus.pci_ad_oe),    32'd0);
        chk("rd0_ctl_oe_turn",  32'(bus.pci_ctl_oe),   32'd1);
        tick();
        chk("rd0_ctl_oe_rel",   32'(bus.pci_ctl_oe),   32'd0);
        bus_idle();
        tick();

        // Config write of offset 1
        addr_phase(32'h0000_0004, 4'hB, 1'b1);
        sb_q.push_back('{iswrite: 1'b1, offset: 6'd1, wval: 32'hDEAD_BEEF});
        tick();
        chk("wr_devsel_claim",  32'(bus.pci_devsel_n), 32'd0);
        chk("wr_cfg_en_claim",  32'(bus.cfg_enable),   32'd0);
        data_phase(1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();
        chk("wr_trdy_data",     32'(bus.pci_trdy_n),   32'd0);
        chk("wr_stop_data",     32'(bus.pci_stop_n),   32'd1);
        chk("wr_ad_oe_data",    32'(bus.pci_ad_oe),    32'd0);
        tick();
        chk("wr_cfg_en_turn",   32'(bus.cfg_enable),   32'd1);
        chk("wr_wval_turn",     bus.cfg_write_val,     32'hDEAD_BEEF);
        chk("wr_trdy_turn",     32'(bus.pci_trdy_n),   32'd1);
        chk("wr_devsel_turn",   32'(bus.pci_devsel_n), 32'd1);
        chk("wr_ctl_oe_turn",   32'(bus.pci_ctl_oe),   32'd1);
        tick();
        chk("wr_ctl_oe_rel",    32'(bus.pci_ctl_oe),   32'd0);
        chk("wr_cfg_en_off",    32'(bus.cfg_enable),   32'd0);
        bus_idle();
        tick();

        // Read of offset 1 with three IRDY# wait states
        addr_phase(32'h0000_0004, 4'hA, 1'b1);
        sb_q.push_back('{iswrite: 1'b0, offset: 6'd1, wval: 32'h0});
        tick();
        data_phase(1'b1, 1'b1, 32'h0);
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("ws_trdy_hold",   32'(bus.pci_trdy_n),   32'd0);
            chk("ws_ad_out_hold", bus.pci_ad_out,        32'hAABB_CCDD);
            chk("ws_devsel_hold", 32'(bus.pci_devsel_n), 32'd0);
            if (i < 2) tick();
        end
        bus.pci_irdy_n = 1'b0;
        tick();
        chk("ws_trdy_done",     32'(bus.pci_trdy_n),   32'd1);
        tick();
        bus_idle();
        tick();

        // Unclaimed addresses; BUSY must persist until FRAME# and IRDY# both high
        for (int k = 0; k < 3; k++) begin
            addr_phase(bad_ad[k], bad_cmd[k], bad_sel[k]);
            tick();
            chk("nm_devsel_addr", 32'(bus.pci_devsel_n), 32'd1);
            chk("nm_ctl_oe_addr", 32'(bus.pci_ctl_oe),   32'd0);
            data_phase(1'b1, 1'b0, 32'h0);
            tick();
            addr_phase(32'h0000_0000, 4'hA, 1'b1);
            tick();
            chk("nm_no_claim_busy", 32'(bus.pci_devsel_n), 32'd1);
            bus_idle();
            tick();
        end

        // Two-phase burst read: disconnect with data, second phase ignored
        addr_phase(32'h0000_0000, 4'hA, 1'b1);
        sb_q.push_back('{iswrite: 1'b0, offset: 6'd0, wval: 32'h0});
        tick();
        data_phase(1'b0, 1'b0, 32'h0);
        tick(); tick();
        chk("bu_trdy_data",     32'(bus.pci_trdy_n),   32'd0);
        chk("bu_stop_data",     32'(bus.pci_stop_n),   32'd0);
        chk("bu_ad_out",        bus.pci_ad_out,        32'h1234_5678);
        tick();
        chk("bu_stop_turn",     32'(bus.pci_stop_n),   32'd1);
        chk("bu_devsel_turn",   32'(bus.pci_devsel_n), 32'd1);
        data_phase(1'b1, 1'b0, 32'h0);
        tick();
        chk("bu_devsel_tail",   32'(bus.pci_devsel_n), 32'd1);
        chk("bu_trdy_tail",     32'(bus.pci_trdy_n),   32'd1);
        bus_idle();
        tick();
        chk("bu_devsel_idle",   32'(bus.pci_devsel_n), 32'd1);

        // Reset asserted during the data phase of a read
        addr_phase(32'h0000_0000, 4'hA, 1'b1);
        sb_q.push_back('{iswrite: 1'b0, offset: 6'd0, wval: 32'h0});
        tick();
        data_phase(1'b1, 1'b1, 32'h0);
        tick(); tick();
        chk("rs_trdy_before",   32'(bus.pci_trdy_n),   32'd0);
        #2 rst = 1'b0;
        #1 chk_reset("rs_async");
        bus_idle();
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        chk("rs_cfg_en_after",  32'(bus.cfg_enable),   32'd0);

        // Fresh read of offset 0 after reset release
        addr_phase(32'h0000_0000, 4'hA, 1'b1);
        sb_q.push_back('{iswrite: 1'b0, offset: 6'd0, wval: 32'h0});
        tick();
        chk("rr_devsel_claim",  32'(bus.pci_devsel_n), 32'd0);
        data_phase(1'b1, 1'b0, 32'h0);
        tick(); tick();
        chk("rr_trdy_data",     32'(bus.pci_trdy_n),   32'd0);
        chk("rr_ad_out",        bus.pci_ad_out,        32'h1234_5678);
        tick(); tick();
        bus_idle();
        tick(); tick();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
